// File: rtl/cdc_ctrl_pkg.sv
// Shared types and constants for the shift-frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cdc_ctrl_pkg;

    // Width of the chain control word owned by the controller.
    localparam int CTL_W = 3;

    // TX frame sequencer states; the encoding is visible on tx_state_o.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        GAP   = 2'd3
    } tx_state_t;

endpackage

// File: rtl/cdc_frame_rx.sv
// Deserialises new_data/data/done frames from the chain, LSB first, and flags malformed frames.
// Latency: rx_data_o/rx_valid_o/rx_err_o update on the clock edge that samples done (one cycle after the done cycle).
// Backpressure: none; frames arrive at the chain's pace and are never stalled.
module cdc_frame_rx
    import cdc_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             rx_new_data_i,
    input  logic             rx_data_i,
    input  logic             rx_done_i,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             rx_err_o,
    output logic [CNT_W-1:0] rx_count_o,
    output logic [CNT_W-1:0] err_count_o
);

    // Bit counter must reach WIDTH itself so a full frame can be told from an overlong one.
    localparam int BW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg_q;
    logic [BW-1:0]    cnt_q;
    logic             active_q;
    logic [WIDTH-1:0] bit_in;

    // Incoming bit placed at the current bit position, OR-ed into the partial word.
    assign bit_in = {{(WIDTH-1){1'b0}}, rx_data_i} << cnt_q;

    // Frame tracking: start, accumulate, close good or bad; status pulses last one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q     <= '0;
            cnt_q       <= '0;
            active_q    <= 1'b0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            rx_err_o    <= 1'b0;
            rx_count_o  <= '0;
            err_count_o <= '0;
        end else begin
            rx_valid_o <= 1'b0;
            rx_err_o   <= 1'b0;
            if (en_i) begin
                if (rx_done_i) begin
                    // done closes an open frame; new_data alongside done is ignored.
                    if (active_q) begin
                        active_q <= 1'b0;
                        if (cnt_q == BW'(WIDTH)) begin
                            rx_data_o  <= shreg_q;
                            rx_valid_o <= 1'b1;
                            rx_count_o <= rx_count_o + CNT_W'(1);
                        end else begin
                            rx_err_o    <= 1'b1;
                            err_count_o <= err_count_o + CNT_W'(1);
                        end
                    end
                end else if (rx_new_data_i) begin
                    // A strobe inside an open frame kills it, but still starts a fresh one.
                    if (active_q) begin
                        rx_err_o    <= 1'b1;
                        err_count_o <= err_count_o + CNT_W'(1);
                    end
                    shreg_q  <= {{(WIDTH-1){1'b0}}, rx_data_i};
                    cnt_q    <= BW'(1);
                    active_q <= 1'b1;
                end else if (active_q) begin
                    if (cnt_q == BW'(WIDTH)) begin
                        // One bit too many: drop the frame; the trailing done is then ignored.
                        rx_err_o    <= 1'b1;
                        err_count_o <= err_count_o + CNT_W'(1);
                        active_q    <= 1'b0;
                    end else begin
                        shreg_q <= shreg_q | bit_in;
                        cnt_q   <= cnt_q + BW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cdc_shift_controller.sv
// Serial frame sequencer: TX word -> new_data/data/done frame, RX frame -> word, plus chain control word.
// Latency: first serial bit the cycle after accept; next accept WIDTH+GAP_CYCLES+1 cycles after the previous one.
// Backpressure: tx_ready_o is high only in IDLE with en_i set; RX has no backpressure.
module cdc_shift_controller
    import cdc_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [CTL_W-1:0] cfg_ctl_i,
    output logic [CTL_W-1:0] ctl_o,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic             shift_new_data_o,
    output logic             shift_data_o,
    output logic             shift_done_o,
    input  logic             rx_new_data_i,
    input  logic             rx_data_i,
    input  logic             rx_done_i,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             rx_err_o,
    output logic [CNT_W-1:0] tx_count_o,
    output logic [CNT_W-1:0] rx_count_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [1:0]       tx_state_o
);

    localparam int BW = $clog2(WIDTH);
    // GAP lasts GAP_CYCLES-1 cycles, so its counter only has to reach GAP_CYCLES-2.
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;

    tx_state_t        state_q;
    tx_state_t        state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [BW-1:0]    bcnt_q;
    logic [GW-1:0]    gcnt_q;
    logic             accept;

    assign accept     = tx_ready_o & tx_valid_i;
    assign tx_state_o = state_q;

    // TX state register; async reset puts the chain back to idle (done=1) immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // TX next state and serial outputs, decoded straight from the state registers.
    always_comb begin
        state_d          = state_q;
        tx_ready_o       = 1'b0;
        shift_new_data_o = 1'b0;
        shift_data_o     = 1'b0;
        shift_done_o     = 1'b1;
        case (state_q)
            IDLE: begin
                tx_ready_o = en_i;
                if (en_i && tx_valid_i) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_done_o     = 1'b0;
                shift_new_data_o = (bcnt_q == '0);
                shift_data_o     = sreg_q[0];
                if (bcnt_q == BW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // DONE already supplies the first idle cycle of the gap.
                if (GAP_CYCLES > 1) begin
                    state_d = GAP;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gcnt_q == GW'(GAP_CYCLES - 2)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // TX datapath: word shifter, bit and gap counters, frame counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q     <= '0;
            bcnt_q     <= '0;
            gcnt_q     <= '0;
            tx_count_o <= '0;
        end else begin
            if (accept) begin
                sreg_q <= tx_data_i;
                bcnt_q <= '0;
            end else if (state_q == SHIFT) begin
                sreg_q <= sreg_q >> 1;
                bcnt_q <= bcnt_q + BW'(1);
            end
            if (state_q == GAP) begin
                gcnt_q <= gcnt_q + GW'(1);
            end else begin
                gcnt_q <= '0;
            end
            if (state_q == DONE) begin
                tx_count_o <= tx_count_o + CNT_W'(1);
            end
        end
    end

    // Control word follows the request only between frames. Loading on the edge into IDLE
    // makes a change requested mid-frame visible in the first IDLE cycle, and the accept
    // cycle itself (still IDLE) latches the word the next frame runs with.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctl_o <= '0;
        end else if ((state_q == IDLE) || (state_d == IDLE)) begin
            ctl_o <= cfg_ctl_i;
        end
    end

    cdc_frame_rx #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_rx (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .rx_new_data_i (rx_new_data_i),
        .rx_data_i     (rx_data_i),
        .rx_done_i     (rx_done_i),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .rx_err_o      (rx_err_o),
        .rx_count_o    (rx_count_o),
        .err_count_o   (err_count_o)
    );

endmodule

// File: tb/tb_cdc_shift_controller.sv
// Directed bench for cdc_shift_controller: reset, TX framing, loopback, RX errors, config gating, mid-frame events.
// Latency: n/a.
// Backpressure: n/a.
module tb_cdc_shift_controller;

    localparam int WIDTH      = 8;
    localparam int GAP_CYCLES = 1;
    localparam int CNT_W      = 8;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             en_i;
    logic [2:0]       cfg_ctl_i;
    logic [2:0]       ctl_o;
    logic [WIDTH-1:0] tx_data_i;
    logic             tx_valid_i;
    logic             tx_ready_o;
    logic             shift_new_data_o;
    logic             shift_data_o;
    logic             shift_done_o;
    logic             rx_new_data_i;
    logic             rx_data_i;
    logic             rx_done_i;
    logic [WIDTH-1:0] rx_data_o;
    logic             rx_valid_o;
    logic             rx_err_o;
    logic [CNT_W-1:0] tx_count_o;
    logic [CNT_W-1:0] rx_count_o;
    logic [CNT_W-1:0] err_count_o;
    logic [1:0]       tx_state_o;

    logic loop;
    logic drv_new;
    logic drv_data;
    logic drv_done;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    assign rx_new_data_i = loop ? shift_new_data_o : drv_new;
    assign rx_data_i     = loop ? shift_data_o     : drv_data;
    assign rx_done_i     = loop ? shift_done_o     : drv_done;

    cdc_shift_controller #(
        .WIDTH      (WIDTH),
        .GAP_CYCLES (GAP_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .en_i             (en_i),
        .cfg_ctl_i        (cfg_ctl_i),
        .ctl_o            (ctl_o),
        .tx_data_i        (tx_data_i),
        .tx_valid_i       (tx_valid_i),
        .tx_ready_o       (tx_ready_o),
        .shift_new_data_o (shift_new_data_o),
        .shift_data_o     (shift_data_o),
        .shift_done_o     (shift_done_o),
        .rx_new_data_i    (rx_new_data_i),
        .rx_data_i        (rx_data_i),
        .rx_done_i        (rx_done_i),
        .rx_data_o        (rx_data_o),
        .rx_valid_o       (rx_valid_o),
        .rx_err_o         (rx_err_o),
        .tx_count_o       (tx_count_o),
        .rx_count_o       (rx_count_o),
        .err_count_o      (err_count_o),
        .tx_state_o       (tx_state_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rx_cycle(input logic n, input logic d, input logic dn);
        drv_new  = n;
        drv_data = d;
        drv_done = dn;
        step();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; en_i = 1'b0; cfg_ctl_i = 3'd0; tx_data_i = '0; tx_valid_i = 1'b0;
        loop = 1'b0; drv_new = 1'b0; drv_data = 1'b0; drv_done = 1'b1;
        repeat (3) step();
        checks++; if (shift_done_o !== 1'b1) begin errors++; $display("FAIL reset_done: got %0b want 1", shift_done_o); end
        checks++; if (tx_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", tx_ready_o); end
        checks++; if (shift_new_data_o !== 1'b0) begin errors++; $display("FAIL reset_new: got %0b want 0", shift_new_data_o); end
        checks++; if (tx_state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", tx_state_o); end
        checks++; if (ctl_o !== 3'd0) begin errors++; $display("FAIL reset_ctl: got %0d want 0", ctl_o); end
        checks++; if ({tx_count_o, rx_count_o, err_count_o} !== '0) begin errors++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", tx_count_o, rx_count_o, err_count_o); end
        checks++; if ({rx_valid_o, rx_err_o, rx_data_o} !== '0) begin errors++; $display("FAIL reset_rx: got v=%0b e=%0b d=%h want 0", rx_valid_o, rx_err_o, rx_data_o); end
        rst_ni = 1'b1;
        step();
        en_i = 1'b1;
        step();
    endtask

    task automatic test_single_tx();
        logic [7:0] w;
        w = 8'hA5;
        tx_data_i = w; tx_valid_i = 1'b1;
        #1;
        checks++; if (tx_ready_o !== 1'b1) begin errors++; $display("FAIL tx_ready_idle: got %0b want 1", tx_ready_o); end
        step();
        tx_valid_i = 1'b0;
        checks++; if (tx_state_o !== 2'd1) begin errors++; $display("FAIL tx_state_shift: got %0d want 1", tx_state_o); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (shift_data_o !== w[k]) begin errors++; $display("FAIL tx_bit%0d: got %0b want %0b", k, shift_data_o, w[k]); end
            checks++; if (shift_new_data_o !== (k == 0)) begin errors++; $display("FAIL tx_new%0d: got %0b want %0b", k, shift_new_data_o, (k == 0)); end
            checks++; if (shift_done_o !== 1'b0) begin errors++; $display("FAIL tx_done%0d: got %0b want 0", k, shift_done_o); end
            checks++; if (tx_ready_o !== 1'b0) begin errors++; $display("FAIL tx_ready%0d: got %0b want 0", k, tx_ready_o); end
            step();
        end
        checks++; if ({shift_done_o, shift_data_o, tx_state_o} !== {1'b1, 1'b0, 2'd2}) begin errors++; $display("FAIL tx_done_cycle: got done=%0b data=%0b st=%0d want 1/0/2", shift_done_o, shift_data_o, tx_state_o); end
        step();
        checks++; if ({tx_state_o, tx_ready_o} !== {2'd0, 1'b1}) begin errors++; $display("FAIL tx_ready_return: got st=%0d rdy=%0b want 0/1", tx_state_o, tx_ready_o); end
        checks++; if (tx_count_o !== 8'd1) begin errors++; $display("FAIL tx_count1: got %0d want 1", tx_count_o); end
    endtask

    task automatic test_loopback();
        logic [7:0] exp_w [3];
        int got;
        logic both;
        exp_w[0] = 8'h3C; exp_w[1] = 8'hFF; exp_w[2] = 8'h00;
        got = 0; both = 1'b0;
        loop = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    int g;
                    g = 0;
                    tx_data_i = exp_w[i]; tx_valid_i = 1'b1;
                    #1;
                    while (!tx_ready_o && g < 40) begin
                        @(posedge clk_i); #1; g++;
                    end
                    if (g >= 40) begin
                        checks++; errors++;
                        $display("FAIL loop_ready_timeout: word %0d never accepted", i);
                    end
                    @(posedge clk_i); #1;
                    tx_valid_i = 1'b0;
                end
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    step();
                    if (rx_valid_o && rx_err_o) both = 1'b1;
                    if (rx_valid_o) begin
                        if (got < 3) begin
                            checks++; if (rx_data_o !== exp_w[got]) begin errors++; $display("FAIL loop_data%0d: got %h want %h", got, rx_data_o, exp_w[got]); end
                        end
                        got++;
                    end
                end
            end
        join
        loop = 1'b0;
        checks++; if (got != 3) begin errors++; $display("FAIL loop_pulses: got %0d want 3", got); end
        checks++; if (both !== 1'b0) begin errors++; $display("FAIL loop_valid_err_overlap: got 1 want 0"); end
        checks++; if (rx_count_o !== 8'd3) begin errors++; $display("FAIL loop_rx_count: got %0d want 3", rx_count_o); end
        checks++; if (err_count_o !== 8'd0) begin errors++; $display("FAIL loop_err_count: got %0d want 0", err_count_o); end
        checks++; if (tx_count_o !== 8'd4) begin errors++; $display("FAIL loop_tx_count: got %0d want 4", tx_count_o); end
    endtask

    task automatic test_rx_errors();
        logic [7:0] w;
        // short frame: 5 bits then done
        rx_cycle(1'b1, 1'b1, 1'b0);
        rx_cycle(1'b0, 1'b0, 1'b0);
        rx_cycle(1'b0, 1'b1, 1'b0);
        rx_cycle(1'b0, 1'b1, 1'b0);
        rx_cycle(1'b0, 1'b0, 1'b0);
        rx_cycle(1'b0, 1'b0, 1'b1);
        checks++; if ({rx_err_o, rx_valid_o} !== 2'b10) begin errors++; $display("FAIL short_pulse: got err=%0b vld=%0b want 1/0", rx_err_o, rx_valid_o); end
        checks++; if (err_count_o !== 8'd1) begin errors++; $display("FAIL short_err_count: got %0d want 1", err_count_o); end
        checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL short_data_kept: got %h want 00", rx_data_o); end
        rx_cycle(1'b0, 1'b0, 1'b1);
        checks++; if (rx_err_o !== 1'b0) begin errors++; $display("FAIL short_err_one_cycle: got %0b want 0", rx_err_o); end
        // overlong frame: 9 bits, error on the 9th, trailing done ignored
        rx_cycle(1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 9; k++) rx_cycle(1'b0, 1'b1, 1'b0);
        checks++; if ({rx_err_o, err_count_o} !== {1'b1, 8'd2}) begin errors++; $display("FAIL long_err: got err=%0b cnt=%0d want 1/2", rx_err_o, err_count_o); end
        rx_cycle(1'b0, 1'b0, 1'b1);
        checks++; if ({rx_err_o, rx_valid_o, err_count_o} !== {2'b00, 8'd2}) begin errors++; $display("FAIL long_tail: got err=%0b vld=%0b cnt=%0d want 0/0/2", rx_err_o, rx_valid_o, err_count_o); end
        // restart mid-frame, then a good frame 8'h96 from the restart
        w = 8'h96;
        rx_cycle(1'b1, 1'b1, 1'b0);
        rx_cycle(1'b0, 1'b1, 1'b0);
        rx_cycle(1'b0, 1'b0, 1'b0);
        rx_cycle(1'b1, w[0], 1'b0);
        checks++; if ({rx_err_o, err_count_o} !== {1'b1, 8'd3}) begin errors++; $display("FAIL restart_err: got err=%0b cnt=%0d want 1/3", rx_err_o, err_count_o); end
        for (int k = 1; k < 8; k++) rx_cycle(1'b0, w[k], 1'b0);
        rx_cycle(1'b0, 1'b0, 1'b1);
        checks++; if ({rx_valid_o, rx_err_o} !== 2'b10) begin errors++; $display("FAIL restart_valid: got vld=%0b err=%0b want 1/0", rx_valid_o, rx_err_o); end
        checks++; if (rx_data_o !== 8'h96) begin errors++; $display("FAIL restart_data: got %h want 96", rx_data_o); end
        checks++; if (rx_count_o !== 8'd4) begin errors++; $display("FAIL restart_rx_count: got %0d want 4", rx_count_o); end
        // new_data together with done is ignored
        rx_cycle(1'b1, 1'b1, 1'b1);
        rx_cycle(1'b0, 1'b0, 1'b1);
        checks++; if ({rx_valid_o, rx_err_o, rx_count_o, err_count_o} !== {2'b00, 8'd4, 8'd3}) begin errors++; $display("FAIL ignore_new_with_done: got vld=%0b err=%0b rx=%0d e=%0d want 0/0/4/3", rx_valid_o, rx_err_o, rx_count_o, err_count_o); end
    endtask

    task automatic test_config_gating();
        cfg_ctl_i = 3'd2;
        step(); step();
        checks++; if (ctl_o !== 3'd2) begin errors++; $display("FAIL cfg_idle_track: got %0d want 2", ctl_o); end
        tx_data_i = 8'h11; tx_valid_i = 1'b1;
        step();
        tx_valid_i = 1'b0;
        step(); step();
        cfg_ctl_i = 3'd5;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++; if (ctl_o !== 3'd2) begin errors++; $display("FAIL cfg_hold%0d: got %0d want 2", k, ctl_o); end
        end
        checks++; if (tx_state_o !== 2'd2) begin errors++; $display("FAIL cfg_done_state: got %0d want 2", tx_state_o); end
        step();
        checks++; if ({tx_state_o, ctl_o} !== {2'd0, 3'd5}) begin errors++; $display("FAIL cfg_apply: got st=%0d ctl=%0d want 0/5", tx_state_o, ctl_o); end
        checks++; if (tx_count_o !== 8'd5) begin errors++; $display("FAIL cfg_tx_count: got %0d want 5", tx_count_o); end
    endtask

    task automatic test_mid_frame();
        // en_i drops at bit 3: frame completes, then IDLE refuses new words
        tx_data_i = 8'h5A; tx_valid_i = 1'b1;
        step();
        tx_valid_i = 1'b0;
        repeat (3) step();
        en_i = 1'b0;
        repeat (4) step();
        checks++; if ({tx_state_o, shift_done_o} !== {2'd1, 1'b0}) begin errors++; $display("FAIL en_drop_bit7: got st=%0d done=%0b want 1/0", tx_state_o, shift_done_o); end
        step();
        checks++; if ({tx_state_o, shift_done_o} !== {2'd2, 1'b1}) begin errors++; $display("FAIL en_drop_done: got st=%0d done=%0b want 2/1", tx_state_o, shift_done_o); end
        step();
        checks++; if ({tx_state_o, tx_ready_o, tx_count_o} !== {2'd0, 1'b0, 8'd6}) begin errors++; $display("FAIL en_drop_idle: got st=%0d rdy=%0b cnt=%0d want 0/0/6", tx_state_o, tx_ready_o, tx_count_o); end
        tx_valid_i = 1'b1;
        step(); step();
        checks++; if ({tx_state_o, tx_ready_o} !== {2'd0, 1'b0}) begin errors++; $display("FAIL en_drop_hold: got st=%0d rdy=%0b want 0/0", tx_state_o, tx_ready_o); end
        tx_valid_i = 1'b0;
        en_i = 1'b1;
        step();
        // async reset at bit 4 with an RX frame also in progress
        tx_data_i = 8'hC3; tx_valid_i = 1'b1;
        drv_new = 1'b1; drv_done = 1'b0; drv_data = 1'b1;
        step();
        tx_valid_i = 1'b0; drv_new = 1'b0;
        repeat (4) step();
        rst_ni = 1'b0;
        #1;
        checks++; if ({shift_done_o, shift_new_data_o, tx_state_o} !== {1'b1, 1'b0, 2'd0}) begin errors++; $display("FAIL rst_mid_tx: got done=%0b new=%0b st=%0d want 1/0/0", shift_done_o, shift_new_data_o, tx_state_o); end
        checks++; if ({tx_count_o, rx_count_o, err_count_o} !== '0) begin errors++; $display("FAIL rst_mid_counts: got %0d/%0d/%0d want 0/0/0", tx_count_o, rx_count_o, err_count_o); end
        step();
        rst_ni = 1'b1;
        drv_done = 1'b1;
        step(); step();
        checks++; if ({rx_err_o, err_count_o, rx_valid_o} !== {1'b0, 8'd0, 1'b0}) begin errors++; $display("FAIL rst_mid_rx_discard: got err=%0b cnt=%0d vld=%0b want 0/0/0", rx_err_o, err_count_o, rx_valid_o); end
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_loopback();
        test_rx_errors();
        test_config_gating();
        test_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cdc_shift_controller.md
Name: cdc_shift_controller

Overview:
- Frame sequencer for the serial shift handshake used by clock_domain_module.
- TX side takes a parallel word with a valid/ready handshake and drives the new_data / data / done_shifting serial frame into the chain.
- RX side deserialises the frame returned by the chain, flags malformed frames and keeps frame/error counters.
- Also owns the chain's 3-bit control word and applies changes only between frames.

Parameters:
- WIDTH, 8, bits per frame (≥2).
- GAP_CYCLES, 1, minimum idle cycles (done=1, new_data=0) between TX frames (≥1).
- CNT_W, 8, width of the frame and error counters.

Ports:
- clk_i  in  1  system clock; sole clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  global enable; when 0, TX does not start new frames and RX ignores inputs.
- cfg_ctl_i  in  3  requested chain control word.
- ctl_o  out  3  applied control word to the chain.
- tx_data_i  in  WIDTH  word to send.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  controller accepts the word this cycle.
- shift_new_data_o  out  1  frame-start strobe to the chain.
- shift_data_o  out  1  serial data to the chain.
- shift_done_o  out  1  done_shifting to the chain; high when idle.
- rx_new_data_i  in  1  frame-start strobe from the chain.
- rx_data_i  in  1  serial data from the chain.
- rx_done_i  in  1  done_shifting from the chain.
- rx_data_o  out  WIDTH  last received word.
- rx_valid_o  out  1  one-cycle pulse when a good frame completes.
- rx_err_o  out  1  one-cycle pulse on a malformed frame.
- tx_count_o  out  CNT_W  frames sent.
- rx_count_o  out  CNT_W  good frames received.
- err_count_o  out  CNT_W  malformed frames.
- tx_state_o  out  2  TX state encoding, for debug.

Behaviour:
- Reset values: all outputs 0, except shift_done_o=1 and tx_state_o=IDLE (2'd0).
- TX state machine, encoding IDLE=0, SHIFT=1, DONE=2, GAP=3.
- IDLE:
  - tx_ready_o = en_i.
  - On tx_valid_i & tx_ready_o, register the word and go to SHIFT.
  - In that same transfer cycle, ctl_o <= cfg_ctl_i. Otherwise ctl_o tracks cfg_ctl_i only while in IDLE.
- SHIFT: lasts exactly WIDTH cycles, sending LSB first.
  - Cycle 0: shift_new_data_o=1, shift_done_o=0, shift_data_o=bit0.
  - Cycles 1..WIDTH-1: new_data_o=0, done_o=0, data_o=bit k.
  - Then go to DONE.
- DONE: one cycle, shift_done_o=1, data_o=0. Increment tx_count_o (wraps at 2^CNT_W). Go to GAP.
- GAP: shift_done_o=1 for GAP_CYCLES-1 further cycles, then IDLE.
  - Total latency from accept to the next possible accept is WIDTH+GAP_CYCLES+1 cycles.
- tx_ready_o is 0 outside IDLE.
- en_i falling mid-frame does not abort the frame; the frame completes, then IDLE holds tx_ready_o=0.
- RX receiver:
  - rx_new_data_i=1 while rx_done_i=0 starts a frame: capture rx_data_i as bit0, set bit counter=1.
  - Each following cycle with rx_done_i=0 and rx_new_data_i=0 captures the next bit.
  - On rx_done_i=1 with counter==WIDTH: rx_data_o updates, rx_valid_o pulses in the next cycle, rx_count_o increments.
- RX error cases; each pulses rx_err_o, increments err_count_o, discards the partial word, and leaves rx_data_o unchanged:
  - rx_done_i rises with counter<WIDTH.
  - More than WIDTH bits arrive.
  - rx_new_data_i reasserts mid-frame; that cycle also restarts a new frame as bit0.
- rx_new_data_i together with rx_done_i=1 is ignored.
- Counters saturate? No: all counters wrap.
- rx_valid_o and rx_err_o are never high together.
- Asynchronous reset mid-frame: TX returns to IDLE with done=1 and RX discards its partial word, both immediately.

Decomposition:
- Package cdc_ctrl_pkg holds:
  - typedef enum logic[1:0] tx_state_t {IDLE, SHIFT, DONE, GAP};
  - localparam CTL_W=3.
- One sub-module, cdc_frame_rx, contains the RX deserialiser and its error detection.
- TX state machine and counters stay in the top level.

Test Plan:
- Reset: hold rst_ni=0 while clk_i runs -> shift_done_o=1, tx_ready_o=0, all counters 0, ctl_o=0.
- Single TX: en_i=1, send 8'hA5 -> new_data_o high one cycle with data=1. Serial stream is 1,0,1,0,0,1,0,1. done_o rises after 8 cycles, tx_count_o=1, ready returns after 10 cycles total.
- Loopback: connect shift_* to rx_* and send 8'h3C, 8'hFF, 8'h00 back-to-back -> three rx_valid_o pulses with matching rx_data_o, rx_count_o=3, err_count_o=0.
- Short frame: rx_new_data_i pulse, 5 bits, then rx_done_i=1 -> rx_err_o pulse, err_count_o=1, rx_data_o unchanged.
- Config gating: change cfg_ctl_i 3'd2→3'd5 during SHIFT -> ctl_o stays 2 until the frame ends; it becomes 5 in the first IDLE cycle.
- Mid-frame events: drop en_i at SHIFT bit 3 -> frame still completes and tx_ready_o stays 0. Separately, pull rst_ni low at bit 4 -> done_o=1 immediately and tx_count_o=0.
